// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared modes and arithmetic helpers for the binarised NPU datapath
package npu_pkg;

    typedef enum logic [1:0] {
        MODE_POP  = 2'd0,
        MODE_XNOR = 2'd1,
        MODE_DOT  = 2'd2
    } mode_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Returns {overflow, a + b clamped to 2^width - 1}.
    function automatic logic [64:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int width);
        logic [64:0] sum;
        logic [64:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (65'd1 << width) - 65'd1;
        if (sum > max) return {1'b1, max[63:0]};
        return {1'b0, sum[63:0]};
    endfunction

endpackage

// File: rtl/popcount_tree.sv
// rtl/popcount_tree.sv - combinational recursive popcount, W bits to clog2(W+1) bits
module popcount_tree import npu_pkg::*; #(
    parameter int W = 15
) (
    input  logic [W-1:0]          bits,
    output logic [clog2(W+1)-1:0] count
);

    // Leaves are half/full adder cells; larger widths split and add the halves.
    generate
        if (W == 1) begin : g_wire
            assign count = bits;
        end else if (W == 2) begin : g_ha
            assign count = {bits[1] & bits[0], bits[1] ^ bits[0]};
        end else if (W == 3) begin : g_fa
            assign count = {(bits[0] & bits[1]) | (bits[2] & (bits[0] ^ bits[1])), ^bits};
        end else begin : g_split
            localparam int LO = W / 2;
            localparam int HI = W - LO;
            localparam int CW = clog2(W + 1);
            logic [clog2(LO+1)-1:0] cnt_lo;
            logic [clog2(HI+1)-1:0] cnt_hi;

            popcount_tree #(.W(LO)) u_lo (.bits(bits[LO-1:0]), .count(cnt_lo));
            popcount_tree #(.W(HI)) u_hi (.bits(bits[W-1:LO]), .count(cnt_hi));

            assign count = CW'(cnt_lo) + CW'(cnt_hi);
        end
    endgenerate

endmodule

// File: rtl/popcount_accum.sv
// rtl/popcount_accum.sv - pipelined per-frame popcount/XNOR/dot accumulator with valid/ready result
module popcount_accum import npu_pkg::*; #(
    parameter int IN_W  = 15,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_a,
    input  logic [IN_W-1:0]  in_b,
    input  logic             in_last,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_result,
    output logic             out_sat
);

    localparam int CNT_W = clog2(IN_W + 1);

    logic             advance;
    logic             accept;
    logic             in_frame;
    mode_e            in_mode;
    mode_e            frame_mode;
    mode_e            beat_mode;
    logic [IN_W-1:0]  vec;
    logic [CNT_W-1:0] beat_cnt;

    logic             s1_valid;
    logic             s1_last;
    logic [CNT_W-1:0] s1_cnt;
    mode_e            s1_mode;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] bits;
    logic             sat;
    logic [64:0]      acc_add;
    logic [64:0]      bits_add;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] bits_sum;
    logic             sat_sum;
    logic [ACC_W+1:0] dot;
    logic [2:0]       dot_top;
    logic             dot_ovf;
    logic [ACC_W-1:0] res;
    logic             res_sat;
    logic             unused_hi;

    logic             s2_valid;
    logic [ACC_W-1:0] s2_result;
    logic             s2_sat;

    // The whole pipeline freezes only while a result waits to be taken.
    assign in_ready = !(out_valid && !out_ready);
    assign advance  = in_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        in_mode = MODE_POP;
        if (mode == MODE_XNOR) in_mode = MODE_XNOR;
        else if (mode == MODE_DOT) in_mode = MODE_DOT;
        beat_mode = in_frame ? frame_mode : in_mode;
        vec = (beat_mode == MODE_POP) ? in_a : ~(in_a ^ in_b);
    end

    popcount_tree #(.W(IN_W)) u_tree (.bits(vec), .count(beat_cnt));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_frame   <= 1'b0;
            frame_mode <= MODE_POP;
        end else if (accept) begin
            in_frame <= !in_last;
            if (!in_frame) frame_mode <= in_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_cnt   <= '0;
            s1_mode  <= MODE_POP;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_last  <= in_last;
            s1_cnt   <= beat_cnt;
            s1_mode  <= beat_mode;
        end
    end

    always_comb begin
        acc_add   = sat_add(64'(acc), 64'(s1_cnt), ACC_W);
        bits_add  = sat_add(64'(bits), 64'(IN_W), ACC_W);
        acc_sum   = acc_add[ACC_W-1:0];
        bits_sum  = bits_add[ACC_W-1:0];
        sat_sum   = sat | acc_add[64] | bits_add[64];
        dot       = {1'b0, acc_sum, 1'b0} - {2'b00, bits_sum};
        // Two guard bits: the top three must agree for the value to fit ACC_W signed.
        dot_top   = dot[ACC_W+1:ACC_W-1];
        dot_ovf   = (dot_top != 3'b000) && (dot_top != 3'b111);
        res       = (s1_mode == MODE_DOT) ? dot[ACC_W-1:0] : acc_sum;
        res_sat   = sat_sum | ((s1_mode == MODE_DOT) && dot_ovf);
        unused_hi = ^{acc_add[63:ACC_W], bits_add[63:ACC_W]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            bits      <= '0;
            sat       <= 1'b0;
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_sat    <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid && s1_last;
            if (s1_valid) begin
                if (s1_last) begin
                    acc       <= '0;
                    bits      <= '0;
                    sat       <= 1'b0;
                    s2_result <= res;
                    s2_sat    <= res_sat;
                end else begin
                    acc  <= acc_sum;
                    bits <= bits_sum;
                    sat  <= sat_sum;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_sat    <= 1'b0;
        end else if (advance && s2_valid) begin
            out_valid  <= 1'b1;
            out_result <= s2_result;
            out_sat    <= s2_sat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_popcount_accum.sv
// tb/tb_popcount_accum.sv - self-checking bench for popcount_accum at ACC_W 16 and 6
module tb_popcount_accum;

    typedef struct packed {
        logic [15:0] r16;
        logic        s16;
        logic [5:0]  r6;
        logic        s6;
    } exp_t;

    typedef struct {
        logic [1:0]  m0;
        logic [1:0]  mr;
        int          n;
        logic [14:0] a0;
        logic [14:0] b0;
        logic [14:0] ar;
        logic [14:0] br;
        exp_t        e;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [14:0] in_a;
    logic [14:0] in_b;
    logic [1:0]  mode;
    logic        in_ready, out_valid, out_sat;
    logic [15:0] out_result;
    logic        in_ready6, out_valid6, out_sat6;
    logic [5:0]  out_result6;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    bit   lat_check = 1'b0;
    bit   rnd_on = 1'b0;
    exp_t exp_q[$];
    int   last_t_q[$];
    int   hs_cyc[$];
    exp_t mon_e;
    int   mon_t;
    frame_t tbl[11];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    popcount_accum #(.IN_W(15), .ACC_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_sat(out_sat)
    );

    popcount_accum #(.IN_W(15), .ACC_W(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mode(mode),
        .out_valid(out_valid6), .out_ready(out_ready), .out_result(out_result6), .out_sat(out_sat6)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: saturate the true frame totals at the accumulator width, then apply the mode rule.
    function automatic void calc(input int w, input int lm, input int sum, input int nbits,
                                 output int res, output bit sat);
        int max, a, b, d;
        max = (1 << w) - 1;
        a   = (sum > max) ? max : sum;
        b   = (nbits > max) ? max : nbits;
        sat = (sum > max) || (nbits > max);
        if (lm == 2) begin
            d = 2 * a - b;
            if (d > (1 << (w - 1)) - 1 || d < -(1 << (w - 1))) sat = 1'b1;
            res = d & max;
        end else begin
            res = a;
        end
    endfunction

    function automatic exp_t model(input int lm, input int sum, input int nbits);
        exp_t e;
        int   r;
        bit   s;
        calc(16, lm, sum, nbits, r, s);
        e.r16 = 16'(r);
        e.s16 = s;
        calc(6, lm, sum, nbits, r, s);
        e.r6 = 6'(r);
        e.s6 = s;
        return e;
    endfunction

    function automatic frame_t mk(input logic [1:0] m0, input logic [1:0] mr, input int n,
                                  input logic [14:0] a0, input logic [14:0] b0,
                                  input logic [14:0] ar, input logic [14:0] br,
                                  input logic [15:0] r16, input logic s16,
                                  input logic [5:0] r6, input logic s6);
        frame_t f;
        f.m0 = m0; f.mr = mr; f.n = n;
        f.a0 = a0; f.b0 = b0; f.ar = ar; f.br = br;
        f.e.r16 = r16; f.e.s16 = s16; f.e.r6 = r6; f.e.s6 = s6;
        return f;
    endfunction

    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready && in_last) last_t_q.push_back(cyc + 1);
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("result16", 64'(out_result), 64'(mon_e.r16));
                check("sat16", 64'(out_sat), 64'(mon_e.s16));
                check("result6", 64'(out_result6), 64'(mon_e.r6));
                check("sat6", 64'(out_sat6), 64'(mon_e.s6));
                check("valid6", 64'(out_valid6), 64'd1);
            end
            if (last_t_q.size() != 0) begin
                mon_t = last_t_q.pop_front();
                if (lat_check) check("latency", 64'(cyc - mon_t), 64'd2);
            end
            hs_cyc.push_back(cyc);
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send_beat(input logic [14:0] a, input logic [14:0] b,
                             input logic [1:0] m, input logic last);
        int tries = 0;
        in_valid = 1'b1; in_a = a; in_b = b; mode = m; in_last = last;
        @(negedge clk);
        while (!in_ready && tries < 200) begin
            @(posedge clk); #1;
            if (rnd_on) out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            tries++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rnd_on) out_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic run_frame(input frame_t f);
        exp_q.push_back(f.e);
        for (int i = 0; i < f.n; i++)
            send_beat(i == 0 ? f.a0 : f.ar, i == 0 ? f.b0 : f.br,
                      i == 0 ? f.m0 : f.mr, 1'(i == f.n - 1));
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [14:0] pick();
        return ($urandom_range(0, 3) == 0) ? 15'h7FFF : 15'($urandom);
    endfunction

    initial begin
        tbl[0]  = mk(2'd0, 2'd0, 1, 15'h7FFF, 15'h0000, 15'h0000, 15'h0000, 16'd15, 1'b0, 6'd15, 1'b0);
        tbl[1]  = mk(2'd1, 2'd1, 3, 15'h1234, 15'h1234, 15'h5555, 15'h5555, 16'd45, 1'b0, 6'd45, 1'b0);
        tbl[2]  = mk(2'd1, 2'd1, 1, 15'h00FF, 15'h7F00, 15'h0000, 15'h0000, 16'd0, 1'b0, 6'd0, 1'b0);
        tbl[3]  = mk(2'd2, 2'd2, 2, 15'h0000, 15'h001F, 15'h0000, 15'h03FF, 16'd0, 1'b0, 6'd0, 1'b0);
        tbl[4]  = mk(2'd2, 2'd2, 2, 15'h7FFF, 15'h0000, 15'h7FFF, 15'h0000, 16'hFFE2, 1'b0, 6'h22, 1'b0);
        tbl[5]  = mk(2'd0, 2'd0, 5, 15'h7FFF, 15'h0000, 15'h7FFF, 15'h0000, 16'd75, 1'b0, 6'd63, 1'b1);
        tbl[6]  = mk(2'd0, 2'd0, 1, 15'h0001, 15'h0000, 15'h0000, 15'h0000, 16'd1, 1'b0, 6'd1, 1'b0);
        tbl[7]  = mk(2'd3, 2'd3, 1, 15'h00F0, 15'h0F0F, 15'h0000, 15'h0000, 16'd4, 1'b0, 6'd4, 1'b0);
        tbl[8]  = mk(2'd1, 2'd0, 2, 15'h0000, 15'h0000, 15'h0003, 15'h0003, 16'd30, 1'b0, 6'd30, 1'b0);
        tbl[9]  = mk(2'd2, 2'd2, 3, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 16'd45, 1'b0, 6'd45, 1'b1);
        tbl[10] = mk(2'd2, 2'd2, 1, 15'h0001, 15'h0000, 15'h0000, 15'h0000, 16'd13, 1'b0, 6'd13, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
        mode = 2'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_in_ready6", 64'(in_ready6), 64'd1);
        check("rst_out_result6", 64'(out_result6), 64'd0);
        @(posedge clk); #1;

        // Back-to-back table frames: values plus exact t+2 latency, which also rules out bubbles.
        lat_check = 1'b1;
        for (int i = 0; i < 11; i++) run_frame(tbl[i]);
        drain("table_drain");
        lat_check = 1'b0;

        // Two results in flight while the consumer stalls.
        out_ready = 1'b0;
        exp_q.push_back('{16'd4, 1'b0, 6'd4, 1'b0});
        send_beat(15'h000F, 15'h0000, 2'd0, 1'b1);
        exp_q.push_back('{16'd8, 1'b0, 6'd8, 1'b0});
        send_beat(15'h00FF, 15'h0000, 2'd0, 1'b1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_result", 64'(out_result), 64'd4);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain("bp_drain");
        check("bp_consecutive", 64'(hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2]), 64'd1);

        // Reset in the middle of a DOT frame; the next frame must start clean in POP.
        send_beat(15'h7FFF, 15'h0000, 2'd2, 1'b0);
        send_beat(15'h7FFF, 15'h0000, 2'd2, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_mid_out_valid", 64'(out_valid), 64'd0);
            check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        end
        @(posedge clk); #1;
        run_frame(mk(2'd0, 2'd0, 1, 15'h007F, 15'h7FFF, 15'h0000, 15'h0000,
                     16'd7, 1'b0, 6'd7, 1'b0));
        drain("rst_drain");

        // Random frames, modes and backpressure against the arithmetic reference.
        rnd_on = 1'b1;
        for (int fr = 0; fr < 60; fr++) begin
            logic [14:0] ra[6];
            logic [14:0] rb[6];
            logic [1:0]  m0;
            int          n, lm, sum, nbits;
            n = $urandom_range(1, 6);
            m0 = 2'($urandom_range(0, 3));
            lm = (m0 == 2'd1 || m0 == 2'd2) ? int'(m0) : 0;
            sum = 0;
            nbits = 0;
            for (int i = 0; i < n; i++) begin
                ra[i] = pick();
                rb[i] = pick();
                sum += (lm == 0) ? $countones(ra[i]) : $countones(~(ra[i] ^ rb[i]));
                nbits += 15;
            end
            exp_q.push_back(model(lm, sum, nbits));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                send_beat(ra[i], rb[i], i == 0 ? m0 : 2'($urandom_range(0, 3)), 1'(i == n - 1));
            end
        end
        rnd_on = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain("rnd_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/popcount_accum.md
# popcount_accum

Parametrised, pipelined popcount accumulator for the binarised datapath of the NPU. Each accepted beat's IN_W-bit vector is compressed to a count. Beats are summed over a frame that ends with `in_last`, and the frame total is returned through a valid/ready output register. It generalises the fixed 15-to-4 compressor to any width, adds XNOR and signed-dot modes, backpressure and saturation. It sits between the binarised activation/weight fetch and the threshold/activation unit.

## Interface
- `IN_W`, 15: bits per input beat (1..64).
- `ACC_W`, 16: accumulator and result width (≥ CNT_W+1).
- `CNT_W`, derived = clog2(IN_W+1): per-beat count width.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset; synchronous and active-low.
- `in_valid`, in, 1: beat valid.
- `in_ready`, out, 1: beat accepted when `in_valid && in_ready`.
- `in_a`, in, IN_W: activation bits.
- `in_b`, in, IN_W: weight bits (ignored in mode POP).
- `in_last`, in, 1: final beat of frame.
- `mode`, in, 2: 0 POP = popcount(a); 1 XNOR = popcount(~(a^b)); 2 DOT = 2·popcount(~(a^b)) − total bits; 3 is reserved and behaves as POP.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: result consumed when `out_valid && out_ready`.
- `out_result`, out, ACC_W: frame result; two's complement in DOT mode, unsigned otherwise.
- `out_sat`, out, 1: the frame's accumulator or bit counter saturated.

## Operation
- Reset (`rst_n`=0 at an edge): all pipeline valids are 0, the accumulator is 0, the bit counter is 0, `out_valid`=0, `out_result`=0, `out_sat`=0, and `in_ready`=1 from the first cycle after reset.
- Reset mid-frame discards the partial frame and any pending result.
- The frame mode is latched on the first accepted beat of a frame. Changes on `mode` mid-frame are ignored until the beat after `in_last`.
- Stage S1 (registered) stores valid, last, and the beat count. Beat count = popcount of `in_a` (POP) or of `~(in_a ^ in_b)` (XNOR/DOT), CNT_W bits.
- Stage S2 runs when S1 is valid:
  - acc ← acc + count, saturating at 2^ACC_W−1.
  - bits ← bits + IN_W, saturating.
  - Either saturation sets a sticky sat flag for the frame.
- On S1 last:
  - The output register loads the result: acc+count (POP/XNOR), or 2·(acc+count) − (bits+IN_W) truncated to ACC_W signed (DOT).
  - `out_sat` loads the sticky flag OR DOT overflow of the signed range.
  - `out_valid` ← 1; acc, bits and sat clear in the same edge.
  - A new frame's first beat may already be in S1 behind it.
- Single-beat frames (first beat = last) are legal.
- Stall: when `out_valid && !out_ready`, `in_ready`=0 and S1/S2 hold. Otherwise `in_ready`=1.
- On a simultaneous output handshake and a new result arriving, the output register reloads and `out_valid` stays 1 (no bubble).
- `in_a`/`in_b` bits above use are not defined; all IN_W bits count.

## Timing
- Latency: a beat with `in_last` accepted at edge t gives `out_valid`=1 after edge t+2.
- Throughput is one beat per cycle with no bubbles, including across frame boundaries, while `out_ready`=1.
- `in_ready` is combinational from `out_valid`/`out_ready` only; it has no path from `in_valid`.
- `out_result`/`out_sat` are registered and stable while `out_valid && !out_ready`.

## Structure
- Package `npu_pkg`:
  - mode enum (MODE_POP, MODE_XNOR, MODE_DOT).
  - `clog2` function.
  - saturating-add helper.
- Sub-module `popcount_tree #(W)`: combinational, recursive carry-save tree of the existing FA/HA cells, W → clog2(W+1) bits. Instantiated once in front of S1.
- The top level holds the mode latch, S1/S2 registers, saturation logic and the output handshake.

## Test plan
- IN_W=15, POP, one beat `in_a`=15'h7FFF, last → `out_result`=15 at t+2, `out_sat`=0.
- XNOR, 3-beat frame with `in_a`=`in_b` each beat, `out_ready`=1 → result 45. A following single-beat frame with `in_a`=~`in_b` → result 0, no bubble between them.
- DOT, 2 beats, matches 10 then 5 (of 15) → 2·15−30 = 0. Second frame with matches 0,0 → −30 (16'hFFE2).
- Backpressure: hold `out_ready`=0 with two frames in flight → `in_ready`=0, first result stable. Release → results delivered in order on consecutive cycles.
- ACC_W=6, POP, 5 beats of all-ones → `out_result`=63, `out_sat`=1. Next frame of 1 beat `in_a`=1 → `out_result`=1, `out_sat`=0.
- Reset asserted after beat 2 of a 4-beat frame → no `out_valid`; a new 1-beat frame of count 7 → `out_result`=7.
